prog_ctr_seq: RTL
=================

# prog_ctr_seq

Program counter sequencer for the 3BC processor, directly downstream of the PC count-enable state bit. It consumes that block's `CountEn` and the decoder's branch/halt controls, and produces the instruction-memory address every cycle. It also tracks run state, raises `Done` on halt, and keeps cycle and instruction counters for the testbench.

## Interface

Parameters
- `PC_W`, 10: program counter width.
- `OFF_W`, 6: relative branch offset width, two's complement.
- `CNT_W`, 16: width of each performance counter.
- `RESET_VEC`, 0: PC value after reset and after restart.

Ports
- `Clk`, input, 1: single clock; all state updates on posedge.
- `Reset_n`, input, 1: synchronous, active-low reset.
- `CountEn`, input, 1: from the PC count-enable bit; 1 = advance, 0 = hold or idle.
- `Halt`, input, 1: decoder flags the current instruction as the done/halt instruction.
- `BranchAbs`, input, 1: current instruction is an absolute jump.
- `BranchRel`, input, 1: current instruction is a relative branch.
- `Taken`, input, 1: branch condition true; qualifies both branch types.
- `Target`, input, `PC_W`: absolute jump target.
- `Offset`, input, `OFF_W`: signed relative offset.
- `ProgCtr`, output, `PC_W`: current instruction address, registered.
- `Done`, output, 1: program has halted, registered.
- `CycleCount`, output, `CNT_W`: cycles spent in RUN.
- `InstrCount`, output, `CNT_W`: instructions retired (PC advances).

## Operation

- States: IDLE, RUN, HALTED. The state encoding is internal.
- Reset (`Reset_n`=0 at posedge) sets:
  - state IDLE
  - `ProgCtr`=`RESET_VEC`
  - `Done`=0
  - `CycleCount`=0 and `InstrCount`=0
- Reset overrides every other input.

IDLE
- `CountEn`=0: hold everything.
- `CountEn`=1: go to RUN. `ProgCtr` is held, so the instruction at `RESET_VEC` executes in the first RUN cycle. Both counters clear. `Done` clears.

RUN
- `CycleCount` increments every cycle, including stalls.
- `CountEn`=0: stall. `ProgCtr` and `InstrCount` hold and the state stays RUN.
- `CountEn`=1: next PC is chosen by fixed priority:
  1. `Halt`: go to HALTED, `Done` becomes 1, `ProgCtr` holds. `InstrCount` increments because the halt instruction retires.
  2. `BranchAbs` and `Taken`: `ProgCtr` becomes `Target`.
  3. `BranchRel` and `Taken`: `ProgCtr` becomes `ProgCtr` plus the sign-extended `Offset`, truncated to `PC_W` bits (modulo 2^`PC_W`).
  4. Otherwise: `ProgCtr` becomes `ProgCtr`+1.
- `InstrCount` increments on every `CountEn`=1 cycle in RUN.
- Falling off the end: if option 4 is selected while `ProgCtr` = 2^`PC_W`−1, go to HALTED with `Done`=1 and `ProgCtr` held. There is no wrap to 0.
- `BranchAbs` and `BranchRel` both high with `Taken`: the absolute branch wins.
- `Taken`=0 with either branch flag set: increment.

HALTED
- `ProgCtr`, `Done`=1 and both counters hold.
- `CountEn`=0 (the testbench is pulsing `Start` again): go to IDLE and set `ProgCtr`=`RESET_VEC`. `Done` stays 1 until RUN is entered, and the counters stay readable until then.
- `CountEn`=1: stay HALTED. This is the normal case after a halt.

Counters
- Both counters saturate at all-ones and never wrap.

## Timing

- All outputs are registered, with one-cycle latency from the sampled inputs to the `ProgCtr`/`Done` update.
- Branch resolution has no added bubble: a taken branch sampled at edge N gives `ProgCtr`=target after edge N.
- `Done` rises on the same edge that samples `Halt` with `CountEn`=1.
- Reset asserted mid-RUN or in HALTED takes effect at the next posedge. All outputs are at reset values after that edge.
- Inputs are sampled only at posedge. `Halt`, branch and target inputs are ignored outside RUN and whenever `CountEn`=0.

## Test plan

- **Reset then start:**
  - Stimulus: `Reset_n`=0 for 2 cycles, release, `CountEn`=1 for 5 cycles with no branches.
  - Response: `ProgCtr` goes 0,0,1,2,3; `InstrCount`=4; `CycleCount`=4; `Done`=0.
- **Absolute and relative branches:**
  - Stimulus 1: at PC=3, `BranchAbs`=1, `Taken`=1, `Target`=40.
  - Response 1: PC=40 next cycle.
  - Stimulus 2: at PC=40, `BranchRel`=1, `Taken`=1, `Offset`=6'b111100.
  - Response 2: PC=36.
  - Stimulus 3: same relative branch with `Taken`=0.
  - Response 3: PC=41.
  - Stimulus 4: both branch flags high, `Taken`=1.
  - Response 4: `Target` is used.
- **Stall:**
  - Stimulus: in RUN at PC=5, drop `CountEn` for 3 cycles.
  - Response: PC stays 5 and `InstrCount` is frozen; `CycleCount` rises by 3.
- **Halt and restart:**
  - Stimulus: `Halt`=1 at PC=12.
  - Response: `Done`=1 and PC stays 12 while `CountEn` stays 1.
  - Stimulus: then `CountEn`=0 for 1 cycle.
  - Response: state IDLE, PC=0, `Done` still 1.
  - Stimulus: then `CountEn`=1.
  - Response: `Done`=0 and counters are 0.
- **End of memory and wrap:**
  - Stimulus 1: run with PC=1023 (`PC_W`=10) and no branch.
  - Response 1: `Done`=1 and PC stays 1023.
  - Stimulus 2: from PC=2, relative branch with `Offset`=−4.
  - Response 2: PC=1022.
- **Reset mid-run and saturation:**
  - Stimulus 1: assert `Reset_n`=0 at PC=100 in RUN.
  - Response 1: the next edge gives PC=0, state IDLE, counters 0.
  - Stimulus 2: with `CNT_W`=4, run 20 stall cycles.
  - Response 2: `CycleCount`=15.

Source files
------------

// File: rtl/prog_ctr_seq_if.sv
// Control and status bundle for the program counter sequencer.
// The decoder and count-enable inputs flow in. PC, done and the counters flow out.
interface prog_ctr_seq_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned OFF_W = 6,
    parameter int unsigned CNT_W = 16
);
    logic             CountEn;
    logic             Halt;
    logic             BranchAbs;
    logic             BranchRel;
    logic             Taken;
    logic [PC_W-1:0]  Target;
    logic [OFF_W-1:0] Offset;
    logic [PC_W-1:0]  ProgCtr;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output CountEn, Halt, BranchAbs, BranchRel, Taken, Target, Offset,
        input  ProgCtr, Done, CycleCount, InstrCount
    );

    modport slave (
        input  CountEn, Halt, BranchAbs, BranchRel, Taken, Target, Offset,
        output ProgCtr, Done, CycleCount, InstrCount
    );
endinterface

// File: rtl/prog_ctr_seq.sv
// Program counter sequencer for the 3BC processor. It selects the next instruction address,
// tracks IDLE/RUN/HALTED, and keeps saturating cycle and retired-instruction counters.
module prog_ctr_seq #(
    parameter int unsigned    PC_W      = 10,
    parameter int unsigned    OFF_W     = 6,
    parameter int unsigned    CNT_W     = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input logic           Clk,
    input logic           Reset_n,
    prog_ctr_seq_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic [PC_W-1:0]  offset_ext;
    logic [CNT_W-1:0] cyc_inc, ins_inc;

    assign offset_ext = {{(PC_W - OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};

    // Counters stick at all-ones instead of wrapping.
    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    assign ins_inc = (ins_q == '1) ? ins_q : ins_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        case (state_q)
            StIdle: begin
                if (bus.CountEn) begin
                    state_d = StRun;
                    done_d  = 1'b0;
                    cyc_d   = '0;
                    ins_d   = '0;
                end
            end
            StRun: begin
                cyc_d = cyc_inc;
                if (bus.CountEn) begin
                    ins_d = ins_inc;
                    if (bus.Halt) begin
                        state_d = StHalted;
                        done_d  = 1'b1;
                    end else if (bus.BranchAbs && bus.Taken) begin
                        pc_d = bus.Target;
                    end else if (bus.BranchRel && bus.Taken) begin
                        pc_d = pc_q + offset_ext;
                    end else if (pc_q == '1) begin
                        // Sequential fetch past the top of memory halts rather than wrapping.
                        state_d = StHalted;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StHalted: begin
                if (!bus.CountEn) begin
                    state_d = StIdle;
                    pc_d    = RESET_VEC;
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_VEC;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    assign bus.ProgCtr    = pc_q;
    assign bus.Done       = done_q;
    assign bus.CycleCount = cyc_q;
    assign bus.InstrCount = ins_q;

endmodule
